verificador_paridade_serial: RTL and testbench

//   Receive end of the 9-bit parity link: 8 data bits plus 1 parity bit.

---
 rtl/verificador_paridade_serial_if.sv | 25 ++
 rtl/verificador_paridade_serial.sv | 105 ++++++++++
 tb/tb_verificador_paridade_serial.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/verificador_paridade_serial_if.sv
// Bus bundle for the serial parity receiver: serial bit stream in, checked words out.
interface verificador_paridade_serial_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              bit_in;
    logic              bit_valid;
    logic              sof;
    logic              clr_count;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_abort;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output bit_in, bit_valid, sof, clr_count,
        input  data_out, data_valid, parity_err, frame_abort, err_count
    );

    modport slave (
        input  bit_in, bit_valid, sof, clr_count,
        output data_out, data_valid, parity_err, frame_abort, err_count
    );
endinterface

// File: rtl/verificador_paridade_serial.sv
// Receive end of the parity link: deserialises DATA_W data bits (LSB first) plus a
// trailing parity bit, flags parity failures and keeps a saturating failure count.
module verificador_paridade_serial #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0,
    parameter int CNT_W      = 8
) (
    input logic clk,
    input logic rst,
    verificador_paridade_serial_if.slave bus
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DATA_W);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CNT_W-1:0] ERR_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};
    localparam logic             ODD_BIT  = 1'(PARITY_ODD);

    typedef enum logic [0:0] {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic [DATA_W-1:0] shift_r;
    logic              last_bit_s;
    logic              err_now_s;

    function automatic logic parity_fail(input logic [DATA_W-1:0] d, input logic p);
        return (^{p, d}) ^ ODD_BIT;
    endfunction

    // Detects the cycle in which the parity bit of a frame is accepted, and whether it fails.
    always_comb begin
        last_bit_s = 1'b0;
        err_now_s  = 1'b0;
        if (state_r == RECV && bus.bit_valid && !bus.sof && cnt_r == CNT_LAST) begin
            last_bit_s = 1'b1;
            err_now_s  = parity_fail(shift_r, bus.bit_in);
        end else begin
            last_bit_s = 1'b0;
            err_now_s  = 1'b0;
        end
    end

    // Frame FSM, deserialiser, registered result outputs and error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= IDLE;
            cnt_r            <= '0;
            shift_r          <= '0;
            bus.data_out     <= '0;
            bus.data_valid   <= 1'b0;
            bus.parity_err   <= 1'b0;
            bus.frame_abort  <= 1'b0;
            bus.err_count    <= '0;
        end else begin
            bus.data_valid  <= 1'b0;
            bus.frame_abort <= 1'b0;
            if (bus.bit_valid) begin
                case (state_r)
                    IDLE: begin
                        if (bus.sof) begin
                            shift_r <= {bus.bit_in, {(DATA_W-1){1'b0}}};
                            cnt_r   <= CNT_ONE;
                            state_r <= RECV;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    RECV: begin
                        if (bus.sof) begin
                            // A new sof drops the partial frame and starts over from bit 0.
                            bus.frame_abort <= 1'b1;
                            shift_r         <= {bus.bit_in, {(DATA_W-1){1'b0}}};
                            cnt_r           <= CNT_ONE;
                        end else if (last_bit_s) begin
                            bus.data_out   <= shift_r;
                            bus.parity_err <= err_now_s;
                            bus.data_valid <= 1'b1;
                            cnt_r          <= '0;
                            state_r        <= IDLE;
                        end else begin
                            shift_r <= {bus.bit_in, shift_r[DATA_W-1:1]};
                            cnt_r   <= cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end

            // Clear takes effect before the count, so a coincident error leaves 1.
            if (bus.clr_count) begin
                bus.err_count <= err_now_s ? ERR_ONE : '0;
            end else if (err_now_s && bus.err_count != ERR_MAX) begin
                bus.err_count <= bus.err_count + ERR_ONE;
            end else begin
                bus.err_count <= bus.err_count;
            end
        end
    end
endmodule

// File: tb/tb_verificador_paridade_serial.sv
// Directed bench for the serial parity receiver: even-parity DUT plus an odd-parity twin.
module tb_verificador_paridade_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   dv_cnt = 0;
    int   abort_cnt = 0;
    int   dv_base;
    int   abort_base;

    verificador_paridade_serial_if #(.DATA_W(8), .CNT_W(8)) bus ();
    verificador_paridade_serial_if #(.DATA_W(8), .CNT_W(8)) bus_odd ();

    verificador_paridade_serial #(.DATA_W(8), .PARITY_ODD(0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    verificador_paridade_serial #(.DATA_W(8), .PARITY_ODD(1), .CNT_W(8)) dut_odd (
        .clk(clk), .rst(rst), .bus(bus_odd.slave)
    );

    assign bus_odd.bit_in    = bus.bit_in;
    assign bus_odd.bit_valid = bus.bit_valid;
    assign bus_odd.sof       = bus.sof;
    assign bus_odd.clr_count = bus.clr_count;

    always #5 clk = ~clk;

    // Pulse counters, used to prove exactly one data_valid / frame_abort per event.
    always @(posedge clk) begin
        if (bus.data_valid === 1'b1) dv_cnt <= dv_cnt + 1;
        if (bus.frame_abort === 1'b1) abort_cnt <= abort_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic s, input logic clr);
        bus.bit_in    = b;
        bus.sof       = s;
        bus.clr_count = clr;
        bus.bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.clr_count = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rest(input logic [7:0] d, input logic p, input logic clr);
        for (int i = 1; i < 8; i++) send_bit(d[i], 1'b0, 1'b0);
        send_bit(p, 1'b0, clr);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p);
        send_bit(d[0], 1'b1, 1'b0);
        send_rest(d, p, 1'b0);
    endtask

    task automatic check_result(input string tag, input logic [7:0] d, input logic pe, input logic [7:0] cnt);
        check_eq({tag, "_dv"}, 32'(bus.data_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(bus.data_out), 32'(d));
        check_eq({tag, "_perr"}, 32'(bus.parity_err), 32'(pe));
        check_eq({tag, "_cnt"}, 32'(bus.err_count), 32'(cnt));
    endtask

    int gaps [9] = '{0, 3, 5, 1, 2, 4, 0, 5, 2};
    logic [7:0] frame_3c = 8'h3C;

    initial begin
        bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.sof = 1'b0; bus.clr_count = 1'b0;
        idle(2);
        check_eq("rst_data", 32'(bus.data_out), 32'd0);
        check_eq("rst_dv", 32'(bus.data_valid), 32'd0);
        check_eq("rst_perr", 32'(bus.parity_err), 32'd0);
        check_eq("rst_abort", 32'(bus.frame_abort), 32'd0);
        check_eq("rst_cnt", 32'(bus.err_count), 32'd0);
        rst = 1'b0;
        idle(1);

        // 1: good even-parity frame
        send_frame(8'hA5, 1'b0);
        check_result("t1", 8'hA5, 1'b0, 8'd0);
        check_eq("t1_odd_perr", 32'(bus_odd.parity_err), 32'd1);
        idle(1);
        check_eq("t1_pulse", 32'(bus.data_valid), 32'd0);
        check_eq("t1_hold", 32'(bus.data_out), 32'hA5);

        // 2: bad parity, then injector-style flip, back-to-back
        send_frame(8'hA5, 1'b1);
        check_result("t2a", 8'hA5, 1'b1, 8'd1);
        check_eq("t2_odd_perr", 32'(bus_odd.parity_err), 32'd0);
        send_frame(8'hAD, 1'b0);
        check_result("t2b", 8'hAD, 1'b1, 8'd2);

        // 3: gaps inside a frame
        idle(1);
        dv_base = dv_cnt;
        for (int i = 0; i < 9; i++) begin
            if (gaps[i] > 0) idle(gaps[i]);
            send_bit((i < 8) ? frame_3c[i] : 1'b0, (i == 0), 1'b0);
        end
        check_result("t3", 8'h3C, 1'b0, 8'd2);
        idle(2);
        check_eq("t3_one_dv", 32'(dv_cnt - dv_base), 32'd1);

        // 4: abort after 4 bits, then full 0x0F
        dv_base = dv_cnt;
        abort_base = abort_cnt;
        send_bit(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        check_eq("t4_abort", 32'(bus.frame_abort), 32'd1);
        send_rest(8'h0F, 1'b0, 1'b0);
        check_eq("t4_abort_end", 32'(bus.frame_abort), 32'd0);
        check_result("t4", 8'h0F, 1'b0, 8'd2);
        idle(2);
        check_eq("t4_one_dv", 32'(dv_cnt - dv_base), 32'd1);
        check_eq("t4_one_abort", 32'(abort_cnt - abort_base), 32'd1);

        // 5: clear, saturation, clear coinciding with an error
        bus.clr_count = 1'b1;
        idle(1);
        bus.clr_count = 1'b0;
        check_eq("t5_clr", 32'(bus.err_count), 32'd0);
        for (int i = 0; i < 300; i++) send_frame(8'hA5, 1'b1);
        check_eq("t5_sat", 32'(bus.err_count), 32'd255);
        send_bit(1'b1, 1'b1, 1'b0);
        send_rest(8'hA5, 1'b1, 1'b1);
        check_eq("t5_clr_err", 32'(bus.err_count), 32'd1);

        // 6: reset mid-frame
        send_bit(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_data", 32'(bus.data_out), 32'd0);
        check_eq("t6_rst_perr", 32'(bus.parity_err), 32'd0);
        check_eq("t6_rst_cnt", 32'(bus.err_count), 32'd0);
        idle(2);
        rst = 1'b0;
        dv_base = dv_cnt;
        idle(3);
        check_eq("t6_no_pulse", 32'(dv_cnt - dv_base), 32'd0);
        send_frame(8'h81, 1'b0);
        check_result("t6", 8'h81, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
